// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - preset min:sec:fraction countdown timer with run/pause/expire control
module countdown_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MAX_MIN       = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] count_min,
    output logic [5:0] count_sec,
    output logic [6:0] count_frac,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [6:0] FRAC_TOP = 7'(TICKS_PER_SEC - 1);
    localparam logic [6:0] MIN_CAP  = 7'(MAX_MIN);
    localparam logic [5:0] SEC_TOP  = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [6:0] frac_q, frac_d;
    logic       running_q, running_d;
    logic       expired_q, expired_d;
    logic       done_q, done_d;

    logic count_is_zero;
    logic count_is_one;

    assign count_is_zero = (min_q == 7'd0) && (sec_q == 6'd0) && (frac_q == 7'd0);
    assign count_is_one  = (min_q == 7'd0) && (sec_q == 6'd0) && (frac_q == 7'd1);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        frac_d  = frac_q;
        done_d  = 1'b0;

        if (load) begin
            min_d   = (preset_min > MIN_CAP) ? MIN_CAP : preset_min;
            sec_d   = (preset_sec > SEC_TOP) ? SEC_TOP : preset_sec;
            frac_d  = 7'd0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !count_is_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (count_is_one) begin
                            frac_d  = 7'd0;
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else if (!count_is_zero) begin
                            // Borrow ripples fraction -> seconds -> minutes.
                            if (frac_q != 7'd0) begin
                                frac_d = frac_q - 7'd1;
                            end else begin
                                frac_d = FRAC_TOP;
                                if (sec_q != 6'd0) begin
                                    sec_d = sec_q - 6'd1;
                                end else begin
                                    sec_d = SEC_TOP;
                                    min_d = min_q - 7'd1;
                                end
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    min_d  = 7'd0;
                    sec_d  = 6'd0;
                    frac_d = 7'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            min_q     <= 7'd0;
            sec_q     <= 6'd0;
            frac_q    <= 7'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            frac_q    <= frac_d;
            running_q <= running_d;
            expired_q <= expired_d;
            done_q    <= done_d;
        end
    end

    assign count_min  = min_q;
    assign count_sec  = sec_q;
    assign count_frac = frac_q;
    assign running    = running_q;
    assign expired    = expired_q;
    assign done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer with directed vectors
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [6:0] preset_min = 7'd0;
    logic [5:0] preset_sec = 6'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] count_min;
    logic [5:0] count_sec;
    logic [6:0] count_frac;
    logic       running;
    logic       expired;
    logic       done;

    countdown_timer #(.TICKS_PER_SEC(100), .MAX_MIN(99)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .start      (start),
        .pause      (pause),
        .count_min  (count_min),
        .count_sec  (count_sec),
        .count_frac (count_frac),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] m;
        logic [5:0] s;
        logic [6:0] f;
        logic       r;
        logic       e;
        logic       d;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: registered outputs are sampled on the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t x;
            x = sb_q.pop_front();
            vectors++;
            if (x.cyc < cyc) begin
                miscompares++;
                $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", x.name, x.cyc, cyc);
            end else if (count_min !== x.m || count_sec !== x.s || count_frac !== x.f ||
                         running !== x.r || expired !== x.e || done !== x.d) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d:%0d r=%b e=%b d=%b, want %0d:%0d:%0d r=%b e=%b d=%b",
                         x.name, count_min, count_sec, count_frac, running, expired, done,
                         x.m, x.s, x.f, x.r, x.e, x.d);
            end
        end
    end

    task automatic cycle_in(input logic t, input logic l, input logic s, input logic p);
        tick  = t;
        load  = l;
        start = s;
        pause = p;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic expect_now(input string name, input int m, input int s, input int f,
                              input logic r, input logic e, input logic d);
        exp_t x;
        x.cyc  = cyc;
        x.name = name;
        x.m    = 7'(m);
        x.s    = 6'(s);
        x.f    = 7'(f);
        x.r    = r;
        x.e    = e;
        x.d    = d;
        sb_q.push_back(x);
    endtask

    task automatic do_load(input int m, input int s);
        preset_min = 7'(m);
        preset_sec = 6'(s);
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state and ticks while idle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_now("reset_state", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("idle_ticks", 0, 0, 0, 0, 0, 0);

        // 2: 0:02 countdown to expiry
        do_load(0, 2);
        expect_now("load_0_02", 0, 2, 0, 0, 0, 0);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("start_0_02", 0, 2, 0, 1, 0, 0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("tick1", 0, 1, 99, 1, 0, 0);
        for (int i = 2; i <= 199; i++) cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("tick199", 0, 0, 1, 1, 0, 0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("tick200_done", 0, 0, 0, 0, 1, 1);
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0);
        expect_now("done_one_cycle", 0, 0, 0, 0, 1, 0);
        cycle_in(1'b1, 1'b0, 1'b1, 1'b1);
        expect_now("expired_ignores", 0, 0, 0, 0, 1, 0);

        // 3: borrow through seconds and minutes
        do_load(1, 0);
        expect_now("load_1_00", 1, 0, 0, 0, 0, 0);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("borrow_chain", 0, 59, 99, 1, 0, 0);

        // 4: pause/resume with coincident ticks
        do_load(0, 5);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("run_30_ticks", 0, 4, 70, 1, 0, 0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b1);
        expect_now("pause_with_tick", 0, 4, 70, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("paused_ticks", 0, 4, 70, 0, 0, 0);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("resume", 0, 4, 70, 1, 0, 0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("tick_after_resume", 0, 4, 69, 1, 0, 0);
        cycle_in(1'b0, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b1, 1'b0, 1'b1, 1'b0);
        expect_now("resume_with_tick", 0, 4, 69, 1, 0, 0);

        // 5: clamping and zero start
        do_load(120, 63);
        expect_now("clamp_load", 99, 59, 0, 0, 0, 0);
        do_load(0, 0);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("zero_start", 0, 0, 0, 0, 0, 0);
        cycle_in(1'b1, 1'b0, 1'b1, 1'b0);
        expect_now("zero_start_again", 0, 0, 0, 0, 0, 0);

        // 6: load and reset abort a running countdown
        do_load(0, 4);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 90; i++) cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("run_to_3_10", 0, 3, 10, 1, 0, 0);
        preset_min = 7'd5;
        preset_sec = 6'd0;
        cycle_in(1'b1, 1'b1, 1'b0, 1'b0);
        expect_now("load_over_tick", 5, 0, 0, 0, 0, 0);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("run_5_00", 4, 59, 99, 1, 0, 0);
        reset = 1'b1;
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        expect_now("reset_mid_run", 0, 0, 0, 0, 0, 0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("after_reset", 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        while (sb_q.size() > 0) begin
            exp_t x;
            x = sb_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation for cycle %0d never checked", x.name, x.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
